spram_ctrl: RTL and testbench



---
 rtl/spram_pkg.sv | 19 +
 rtl/spram_ctrl.sv | 90 +++++++++
 tb/tb_spram_ctrl.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/spram_pkg.sv
// Shared definitions for the single-port RAM controller: FSM states and
// default geometry of the 8x64 RAM macro.
package spram_pkg;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned ADDR_W     = 6;
  localparam int unsigned DEPTH      = 64;
  localparam int unsigned RD_LATENCY = 1;
  // Counter is sized for the largest supported read latency (4).
  localparam int unsigned CNT_W      = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/spram_ctrl.sv
// Request-side controller for the single-port RAM: one operation in flight,
// registered RAM pins, timed read capture and a valid/ready response channel.
module spram_ctrl
  import spram_pkg::*;
#(
  parameter int unsigned DATA_W     = spram_pkg::DATA_W,
  parameter int unsigned ADDR_W     = spram_pkg::ADDR_W,
  parameter int unsigned RD_LATENCY = spram_pkg::RD_LATENCY
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [DATA_W-1:0] ram_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_q,
  output logic              busy
);

  state_t           state;
  logic             op_we;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      op_we     <= 1'b0;
      cnt       <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_data  <= '0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            ram_addr  <= req_addr;
            op_we     <= req_we;
            ram_we    <= req_we;
            if (req_we) ram_data <= req_wdata;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          ram_we <= 1'b0;
          if (op_we) begin
            req_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            cnt   <= CNT_W'(RD_LATENCY - 1);
            state <= WAIT;
          end
        end
        WAIT: begin
          // q becomes valid RD_LATENCY cycles after the end-of-ISSUE edge.
          if (cnt == '0) begin
            rsp_rdata <= ram_q;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spram_ctrl.sv
// Bench for spram_ctrl: two controllers (read latency 1 and 3), each on its
// own behavioural RAM, checked against an array model and fixed cycle timing.
module tb_spram_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid [2];
  logic       req_ready [2];
  logic       req_we    [2];
  logic [5:0] req_addr  [2];
  logic [7:0] req_wdata [2];
  logic       rsp_valid [2];
  logic       rsp_ready [2];
  logic [7:0] rsp_rdata [2];
  logic [7:0] ram_data  [2];
  logic [5:0] ram_addr  [2];
  logic       ram_we    [2];
  logic [7:0] ram_q     [2];
  logic       busy      [2];

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] model      [2][64];
  logic [7:0] last_wdata [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int L = (g == 0) ? 1 : 3;
    logic [7:0] mem  [64];
    logic [7:0] pipe [L];

    spram_ctrl #(.DATA_W(8), .ADDR_W(6), .RD_LATENCY(L)) u_dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_we(req_we[g]),
      .req_addr(req_addr[g]), .req_wdata(req_wdata[g]),
      .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]), .rsp_rdata(rsp_rdata[g]),
      .ram_data(ram_data[g]), .ram_addr(ram_addr[g]), .ram_we(ram_we[g]),
      .ram_q(ram_q[g]), .busy(busy[g])
    );

    // RAM macro model: registered address, q valid L cycles after sampling.
    initial for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    always @(posedge clk) begin
      if (ram_we[g]) mem[ram_addr[g]] <= ram_data[g];
      pipe[0] <= mem[ram_addr[g]];
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign ram_q[g] = pipe[L-1];
  end

  function automatic int lat(int d);
    return (d == 0) ? 1 : 3;
  endfunction

  task automatic check(string tag, int unsigned got, int unsigned exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic do_write(int d, logic [5:0] a, logic [7:0] v);
    check("wr_ready_idle", req_ready[d], 1);
    req_valid[d] = 1'b1; req_we[d] = 1'b1; req_addr[d] = a; req_wdata[d] = v;
    @(posedge clk); @(negedge clk);
    check("wr_we_issue", ram_we[d], 1);
    check("wr_addr", ram_addr[d], a);
    check("wr_data", ram_data[d], v);
    check("wr_ready_issue", req_ready[d], 0);
    check("wr_busy_issue", busy[d], 1);
    req_valid[d] = 1'($urandom); req_we[d] = 1'($urandom);
    req_addr[d] = 6'($urandom); req_wdata[d] = 8'($urandom);
    @(negedge clk);
    req_valid[d] = 1'b0;
    check("wr_we_after", ram_we[d], 0);
    check("wr_ready_after", req_ready[d], 1);
    check("wr_busy_after", busy[d], 0);
    check("wr_no_rsp", rsp_valid[d], 0);
    check("wr_addr_hold", ram_addr[d], a);
    model[d][a]   = v;
    last_wdata[d] = v;
  endtask

  task automatic do_read(int d, logic [5:0] a, int delay, bit noisy);
    int         l   = lat(d);
    logic [7:0] exp = model[d][a];
    rsp_ready[d] = (delay == 0);
    check("rd_ready_idle", req_ready[d], 1);
    req_valid[d] = 1'b1; req_we[d] = 1'b0; req_addr[d] = a; req_wdata[d] = 8'($urandom);
    @(posedge clk);
    for (int k = 1; k < 2 + l; k++) begin
      @(negedge clk);
      check("rd_we_low", ram_we[d], 0);
      check("rd_no_early_rsp", rsp_valid[d], 0);
      check("rd_ready_low", req_ready[d], 0);
      check("rd_busy", busy[d], 1);
      if (k == 1) begin
        check("rd_addr", ram_addr[d], a);
        check("rd_data_hold", ram_data[d], last_wdata[d]);
      end
      if (noisy) begin
        req_valid[d] = 1'b1; req_we[d] = ~req_we[d];
        req_wdata[d] = 8'hFF; req_addr[d] = 6'($urandom);
      end else begin
        req_valid[d] = 1'b0;
      end
    end
    @(negedge clk);
    req_valid[d] = 1'b0;
    check("rd_valid", rsp_valid[d], 1);
    check("rd_rdata", rsp_rdata[d], exp);
    for (int i = 1; i < delay; i++) begin
      @(negedge clk);
      check("rd_valid_hold", rsp_valid[d], 1);
      check("rd_rdata_hold", rsp_rdata[d], exp);
      check("rd_ready_resp", req_ready[d], 0);
      check("rd_busy_resp", busy[d], 1);
      check("rd_we_resp", ram_we[d], 0);
    end
    rsp_ready[d] = 1'b1;
    @(negedge clk);
    check("rd_valid_clear", rsp_valid[d], 0);
    check("rd_ready_back", req_ready[d], 1);
    check("rd_busy_clear", busy[d], 0);
    rsp_ready[d] = 1'b0;
  endtask

  function automatic logic [5:0] pick_addr();
    case ($urandom_range(0, 3))
      0:       return 6'd0;
      1:       return 6'd63;
      default: return 6'($urandom);
    endcase
  endfunction

  initial begin
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = '0; req_wdata[d] = '0;
      rsp_ready[d] = 1'b0; last_wdata[d] = 8'h00;
      for (int i = 0; i < 64; i++) model[d][i] = 8'h00;
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst_rsp_valid", rsp_valid[d], 0);
      check("rst_rsp_rdata", rsp_rdata[d], 0);
      check("rst_ram_we", ram_we[d], 0);
      check("rst_ram_addr", ram_addr[d], 0);
      check("rst_ram_data", ram_data[d], 0);
      check("rst_busy", busy[d], 0);
    end
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) check("rst_req_ready", req_ready[d], 1);

    // Directed cases on the latency-1 controller.
    do_write(0, 6'd3, 8'hA5);
    do_write(0, 6'd63, 8'h3C);
    do_read(0, 6'd63, 0, 1'b0);
    do_write(0, 6'd0, 8'h5A);
    do_read(0, 6'd0, 5, 1'b0);
    do_read(0, 6'd3, 0, 1'b1);
    check("ram_unchanged", g_dut[0].mem[3], 8'hA5);

    // Latency-3 controller.
    do_write(1, 6'd10, 8'h77);
    do_read(1, 6'd10, 0, 1'b0);

    // Randomised traffic on both controllers.
    for (int n = 0; n < 80; n++) begin
      int d = (n % 4 == 3) ? 1 : 0;
      if ($urandom_range(0, 1) == 1)
        do_write(d, pick_addr(), 8'($urandom));
      else
        do_read(d, pick_addr(), $urandom_range(0, 3), 1'($urandom));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    // Reset during WAIT discards the pending read.
    check("rr_ready_idle", req_ready[0], 1);
    req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 6'd3; rsp_ready[0] = 1'b1;
    @(posedge clk); @(negedge clk);
    req_valid[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int d = 0; d < 2; d++) last_wdata[d] = 8'h00;
    check("rr_rsp_valid", rsp_valid[0], 0);
    check("rr_ram_we", ram_we[0], 0);
    check("rr_busy", busy[0], 0);
    check("rr_req_ready", req_ready[0], 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("rr_no_late_rsp", rsp_valid[0], 0);
    end
    rsp_ready[0] = 1'b0;
    do_write(0, 6'd20, 8'hC3);
    do_read(0, 6'd20, 1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
